// File: rtl/pipe_hazard_unit_pkg.sv
// rtl/pipe_hazard_unit_pkg.sv - shared types and constants for the pipeline hazard unit
package pipe_hazard_unit_pkg;

    // Widest register index the scoreboard can hold; narrower indices are zero-extended
    localparam int RD_MAX_W = 8;

    // Default tracked depth and the matching forward-select width
    localparam int DEF_DEPTH = 3;
    localparam int SEL_W     = $clog2(DEF_DEPTH + 1);

    localparam logic [RD_MAX_W-1:0] REG_ZERO = '0;

    // One in-flight result-producing instruction
    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                ren;
        logic                is_load;
    } sb_entry_t;

    // Forward-select width for an arbitrary depth: 0 = register file, k+1 = stage k
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_hazard_match.sv
// rtl/pipe_hazard_unit_hazard_match.sv - youngest-producer search for one source operand
module hazard_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int REG_BITS = 5,
    parameter int LOAD_LAT = 1,
    parameter int FWD_W    = sel_width(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [REG_BITS-1:0]   src,
    input  logic                  src_used,
    output logic [FWD_W-1:0]      sel,
    output logic                  load_use
);

    logic [RD_MAX_W-1:0] src_ext;

    assign src_ext = RD_MAX_W'(src);

    // Scan oldest to youngest so the youngest matching producer overrides older ones
    always_comb begin
        sel      = '0;
        load_use = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].ren && src_used &&
                src_ext != REG_ZERO && entries[k].rd == src_ext) begin
                sel      = FWD_W'(k + 1);
                load_use = entries[k].is_load && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - scoreboard-driven decode stall, operand forwarding and event counters
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int REG_BITS = 5,
    parameter int DATA_W   = 32,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int FWD_W   = sel_width(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [REG_BITS-1:0]     issue_rs,
    input  logic [REG_BITS-1:0]     issue_rt,
    input  logic                    issue_rs_used,
    input  logic                    issue_rt_used,
    input  logic [REG_BITS-1:0]     issue_rd,
    input  logic                    issue_ren,
    input  logic                    issue_is_load,
    input  logic                    redirect,
    input  logic [DATA_W-1:0]       rf_a_data,
    input  logic [DATA_W-1:0]       rf_b_data,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic                    stall,
    output logic                    flush,
    output logic [FWD_W-1:0]        fwd_a_sel,
    output logic [FWD_W-1:0]        fwd_b_sel,
    output logic [DATA_W-1:0]       fwd_a_data,
    output logic [DATA_W-1:0]       fwd_b_data,
    output logic [CNT_W-1:0]        stall_count,
    output logic [CNT_W-1:0]        flush_count
);

    sb_entry_t [DEPTH-1:0] sb;
    logic                  load_use_a;
    logic                  load_use_b;
    logic                  accept;

    hazard_match #(
        .DEPTH    (DEPTH),
        .REG_BITS (REG_BITS),
        .LOAD_LAT (LOAD_LAT),
        .FWD_W    (FWD_W)
    ) u_match_a (
        .entries  (sb),
        .src      (issue_rs),
        .src_used (issue_rs_used),
        .sel      (fwd_a_sel),
        .load_use (load_use_a)
    );

    hazard_match #(
        .DEPTH    (DEPTH),
        .REG_BITS (REG_BITS),
        .LOAD_LAT (LOAD_LAT),
        .FWD_W    (FWD_W)
    ) u_match_b (
        .entries  (sb),
        .src      (issue_rt),
        .src_used (issue_rt_used),
        .sel      (fwd_b_sel),
        .load_use (load_use_b)
    );

    // Redirect wins over a load-use hazard: the wrong-path instruction is killed, not held
    assign stall  = issue_valid && !redirect && (load_use_a || load_use_b);
    assign flush  = redirect;
    assign accept = issue_valid && !stall && !redirect;

    // Operand mux: register file unless a tracked stage holds a newer value
    always_comb begin
        fwd_a_data = rf_a_data;
        fwd_b_data = rf_b_data;
        for (int k = 0; k < DEPTH; k++) begin
            if (fwd_a_sel == FWD_W'(k + 1)) fwd_a_data = stage_data[k*DATA_W +: DATA_W];
            if (fwd_b_sel == FWD_W'(k + 1)) fwd_b_data = stage_data[k*DATA_W +: DATA_W];
        end
    end

    // Shadow scoreboard: advance every cycle, inject the decode instruction or a bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            sb <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb[k] <= sb[k-1];
            end
            if (accept) begin
                sb[0].valid   <= 1'b1;
                sb[0].rd      <= RD_MAX_W'(issue_rd);
                sb[0].ren     <= issue_ren;
                sb[0].is_load <= issue_is_load;
            end else begin
                sb[0] <= '0;
            end
        end
    end

    // Saturating debug counters for stall and flush events
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
            if (redirect && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
